mealy_zero_det: RTL and testbench



---
 rtl/mealy_zero_det.sv | 39 +++
 tb/tb_mealy_zero_det.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mealy_zero_det.sv
// Mealy 1->0 transition detector on a serial bit stream.
// y_out flags the zero that ends a run of ones, with zero clock latency.
module mealy_zero_det (
  output logic y_out,
  input  logic x_in,
  input  logic clock,
  input  logic reset
);

  typedef enum logic [1:0] {
    S0 = 2'b00,  // idle: last sample was 0, or just reset
    S1 = 2'b01,  // exactly one 1 seen
    S2 = 2'b10,  // three or more 1s seen
    S3 = 2'b11   // exactly two 1s seen
  } state_e;

  state_e state_q, state_d;

  always_comb begin
    // NOTE: default assignment first so every path drives state_d (no latch).
    state_d = state_q;
    case (state_q)
      S0: state_d = x_in ? S1 : S0;
      S1: state_d = x_in ? S3 : S0;
      S2: state_d = x_in ? S2 : S0;
      S3: state_d = x_in ? S2 : S0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment; reset is sampled on the edge.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S0;
    else       state_q <= state_d;
  end

  // Output depends only on the state flops and live inputs, never on state_d.
  assign y_out = ~reset & (state_q != S0) & ~x_in;

endmodule

// File: tb/tb_mealy_zero_det.sv
// Scoreboard bench for mealy_zero_det: expected y_out values are queued from a
// reference model when stimulus is applied and popped when the output is sampled.
module tb_mealy_zero_det;

  logic y_out, x_in, clock, reset;
  logic exp_q[$];
  logic [1:0] m_state;
  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [1:0] S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11;

  mealy_zero_det dut (
    .y_out (y_out),
    .x_in  (x_in),
    .clock (clock),
    .reset (reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [1:0] model_next(input logic [1:0] s, input logic x, input logic r);
    if (r) return S0;
    case (s)
      S0:      return x ? S1 : S0;
      S1:      return x ? S3 : S0;
      default: return x ? S2 : S0;
    endcase
  endfunction

  function automatic logic model_y(input logic [1:0] s, input logic x, input logic r);
    return !r && (s != S0) && !x;
  endfunction

  // Drive inputs on the falling edge, then queue the expected output.
  task automatic drive(input logic x, input logic r);
    @(negedge clock);
    x_in  = x;
    reset = r;
    #1;
    exp_q.push_back(model_y(m_state, x_in, reset));
  endtask

  // Change inputs mid-cycle without waiting for an edge.
  task automatic poke(input logic x, input logic r);
    x_in  = x;
    reset = r;
    #1;
    exp_q.push_back(model_y(m_state, x_in, reset));
  endtask

  task automatic tick();
    @(posedge clock);
    m_state = model_next(m_state, x_in, reset);
    #1;
  endtask

  task automatic test_reset();
    logic e;
    logic [1:0] st;
    drive(1'b1, 1'b1);
    e = exp_q.pop_front(); n_checks++;
    if (y_out !== e) $display("FAIL reset_during: y_out=%b expected %b", y_out, e); else n_pass++;
    tick();
    st = dut.state_q; n_checks++;
    if (st !== S0) $display("FAIL reset_state: state=%b expected %b", st, S0); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0);
      e = exp_q.pop_front(); n_checks++;
      if (y_out !== e || y_out !== 1'b0) $display("FAIL reset_idle_y: y_out=%b expected 0", y_out); else n_pass++;
      tick();
      st = dut.state_q; n_checks++;
      if (st !== S0) $display("FAIL reset_idle_state: state=%b expected %b", st, S0); else n_pass++;
    end
  endtask

  task automatic test_single_one();
    logic e;
    logic [1:0] st;
    drive(1'b1, 1'b0);
    e = exp_q.pop_front(); n_checks++;
    if (y_out !== e) $display("FAIL single_high_y: y_out=%b expected %b", y_out, e); else n_pass++;
    tick();
    st = dut.state_q; n_checks++;
    if (st !== S1) $display("FAIL single_state: state=%b expected %b", st, S1); else n_pass++;
    drive(1'b0, 1'b0);
    e = exp_q.pop_front(); n_checks++;
    if (y_out !== e || y_out !== 1'b1) $display("FAIL single_detect: y_out=%b expected 1", y_out); else n_pass++;
    tick();
    exp_q.push_back(model_y(m_state, x_in, reset));
    e = exp_q.pop_front(); n_checks++;
    if (y_out !== e || y_out !== 1'b0) $display("FAIL single_after: y_out=%b expected 0", y_out); else n_pass++;
    st = dut.state_q; n_checks++;
    if (st !== S0) $display("FAIL single_return: state=%b expected %b", st, S0); else n_pass++;
  endtask

  task automatic test_long_run();
    logic e;
    logic [1:0] st;
    logic [1:0] path [5] = '{S1, S3, S2, S2, S2};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0);
      e = exp_q.pop_front(); n_checks++;
      if (y_out !== e || y_out !== 1'b0) $display("FAIL long_y[%0d]: y_out=%b expected 0", i, y_out); else n_pass++;
      tick();
      st = dut.state_q; n_checks++;
      if (st !== path[i]) $display("FAIL long_state[%0d]: state=%b expected %b", i, st, path[i]); else n_pass++;
    end
    drive(1'b0, 1'b0);
    e = exp_q.pop_front(); n_checks++;
    if (y_out !== e || y_out !== 1'b1) $display("FAIL long_detect: y_out=%b expected 1", y_out); else n_pass++;
    tick();
    st = dut.state_q; n_checks++;
    if (st !== S0) $display("FAIL long_return: state=%b expected %b", st, S0); else n_pass++;
  endtask

  task automatic test_glitch();
    logic e;
    logic [1:0] st;
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b0); void'(exp_q.pop_front()); void'(exp_q.pop_front()); tick();
    st = dut.state_q; n_checks++;
    if (st !== S3) $display("FAIL glitch_setup: state=%b expected %b", st, S3); else n_pass++;
    drive(1'b1, 1'b0);
    poke(1'b0, 1'b0);
    poke(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front(); n_checks++;
      if (i == 0 && y_out !== e) $display("FAIL glitch_pre: y_out=%b expected %b", y_out, e);
      else if (i == 0) n_pass++;
      else n_checks--;
    end
    tick();
    st = dut.state_q; n_checks++;
    if (st !== S2) $display("FAIL glitch_state: state=%b expected %b", st, S2); else n_pass++;
    // Re-run the glitch with live sampling of each phase.
    drive(1'b1, 1'b0);
    e = exp_q.pop_front(); n_checks++;
    if (y_out !== e || y_out !== 1'b0) $display("FAIL glitch_hi0: y_out=%b expected 0", y_out); else n_pass++;
    poke(1'b0, 1'b0);
    e = exp_q.pop_front(); n_checks++;
    if (y_out !== e || y_out !== 1'b1) $display("FAIL glitch_low: y_out=%b expected 1", y_out); else n_pass++;
    poke(1'b1, 1'b0);
    e = exp_q.pop_front(); n_checks++;
    if (y_out !== e || y_out !== 1'b0) $display("FAIL glitch_hi1: y_out=%b expected 0", y_out); else n_pass++;
    tick();
    st = dut.state_q; n_checks++;
    if (st !== S2) $display("FAIL glitch_hold: state=%b expected %b", st, S2); else n_pass++;
    drive(1'b0, 1'b0); void'(exp_q.pop_front()); tick();
  endtask

  task automatic test_reset_mid();
    logic e;
    logic [1:0] st;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0); void'(exp_q.pop_front()); tick();
    end
    st = dut.state_q; n_checks++;
    if (st !== S2) $display("FAIL rmid_setup: state=%b expected %b", st, S2); else n_pass++;
    drive(1'b0, 1'b0);
    e = exp_q.pop_front(); n_checks++;
    if (y_out !== e || y_out !== 1'b1) $display("FAIL rmid_detect: y_out=%b expected 1", y_out); else n_pass++;
    poke(1'b0, 1'b1);
    e = exp_q.pop_front(); n_checks++;
    if (y_out !== e || y_out !== 1'b0) $display("FAIL rmid_force: y_out=%b expected 0", y_out); else n_pass++;
    tick();
    st = dut.state_q; n_checks++;
    if (st !== S0) $display("FAIL rmid_state: state=%b expected %b", st, S0); else n_pass++;
    drive(1'b0, 1'b0);
    e = exp_q.pop_front(); n_checks++;
    if (y_out !== e || y_out !== 1'b0) $display("FAIL rmid_release: y_out=%b expected 0", y_out); else n_pass++;
    tick();
  endtask

  task automatic test_alternate();
    logic e;
    logic [1:0] st;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0);
      e = exp_q.pop_front(); n_checks++;
      if (y_out !== e || y_out !== 1'b0) $display("FAIL alt_high_y[%0d]: y_out=%b expected 0", i, y_out); else n_pass++;
      tick();
      st = dut.state_q; n_checks++;
      if (st !== S1) $display("FAIL alt_s1[%0d]: state=%b expected %b", i, st, S1); else n_pass++;
      drive(1'b0, 1'b0);
      e = exp_q.pop_front(); n_checks++;
      if (y_out !== e || y_out !== 1'b1) $display("FAIL alt_low_y[%0d]: y_out=%b expected 1", i, y_out); else n_pass++;
      tick();
      st = dut.state_q; n_checks++;
      if (st !== S0) $display("FAIL alt_s0[%0d]: state=%b expected %b", i, st, S0); else n_pass++;
    end
  endtask

  initial begin
    x_in    = 1'b1;
    reset   = 1'b1;
    m_state = S0;
    test_reset();
    test_single_one();
    test_long_run();
    test_glitch();
    test_reset_mid();
    test_alternate();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
